pipe_ctrl_unit: RTL

//  Pipelined control unit for the ARMv4 core: decodes the instruction in ID and carries control through ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_ctrl_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control for the ARMv4 core: decodes in ID, carries control through
// ID/EX, EX/MEM and MEM/WB, owns the NZCV flags and resolves stalls/redirects.
module pipe_ctrl_unit #(
  parameter int RA_W     = 4,
  parameter int FLUSH_N  = 2,
  parameter int STALL_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [3:0]      id_cond,
  input  logic [1:0]      id_op,
  input  logic [5:0]      id_funct,
  input  logic [RA_W-1:0] id_rd,
  input  logic [RA_W-1:0] id_rn,
  input  logic [RA_W-1:0] id_rm,
  input  logic [3:0]      ex_nzcv,
  output logic            stall_fd,
  output logic            flush_fd,
  output logic            redirect,
  output logic            illegal,
  output logic [3:0]      ex_alufun,
  output logic            ex_imm,
  output logic            ex_cond_ok,
  output logic            mem_re,
  output logic            mem_we,
  output logic            mem_byte,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_rd,
  output logic [1:0]      wb_sel,
  output logic [3:0]      cpsr
);

  localparam logic [RA_W-1:0] PC_REG = '1;
  localparam logic [RA_W-1:0] LR_REG = RA_W'(14);

  typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_UND = 2'b11} op_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_LINK = 2'b10} wb_sel_e;

  typedef struct packed {
    logic            valid;
    logic [3:0]      cond;
    logic [3:0]      alufun;
    logic            imm;
    logic            sets;
    logic            branch;
    logic            pc_write;
    logic            re;
    logic            we;
    logic            byte_acc;
    logic            wr_en;
    logic [RA_W-1:0] rd;
    wb_sel_e         wb_sel;
  } ex_ctrl_t;

  typedef struct packed {
    logic            re;
    logic            we;
    logic            byte_acc;
    logic            wr_en;
    logic [RA_W-1:0] rd;
    wb_sel_e         wb_sel;
  } mem_ctrl_t;

  typedef struct packed {
    logic            wr_en;
    logic [RA_W-1:0] rd;
    wb_sel_e         wb_sel;
  } wb_ctrl_t;

  op_e       id_opc;
  ex_ctrl_t  id_dec, ex_q;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;
  logic      id_legal, uses_rn, uses_rm;
  logic      cond_pass, ex_live, mem_ld_pc, load_use, bubble;

  assign id_opc   = op_e'(id_op);
  assign id_legal = id_valid && (id_opc != OP_UND);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    id_dec       = '0;
    uses_rn      = 1'b0;
    uses_rm      = 1'b0;
    id_dec.valid = id_legal;
    id_dec.cond  = id_cond;
    case (id_opc)
      OP_DP: begin
        id_dec.alufun   = id_funct[4:1];
        id_dec.imm      = id_funct[5];
        id_dec.sets     = id_funct[0];
        id_dec.pc_write = (id_rd == PC_REG);
        id_dec.wr_en    = (id_rd != PC_REG);
        id_dec.rd       = (id_rd != PC_REG) ? id_rd : '0;
        uses_rn         = 1'b1;
        uses_rm         = ~id_funct[5];
      end
      OP_MEM: begin
        id_dec.alufun   = id_funct[3] ? 4'b0100 : 4'b0010;
        id_dec.imm      = ~id_funct[5];
        id_dec.byte_acc = id_funct[2];
        id_dec.re       = id_funct[0];
        id_dec.we       = ~id_funct[0];
        id_dec.wr_en    = id_funct[0];
        id_dec.rd       = id_funct[0] ? id_rd : '0;
        id_dec.wb_sel   = id_funct[0] ? WB_MEM : WB_ALU;
        uses_rn         = 1'b1;
        uses_rm         = id_funct[5];
      end
      OP_BR: begin
        id_dec.alufun = 4'b0100;
        id_dec.imm    = 1'b1;
        id_dec.branch = 1'b1;
        id_dec.wr_en  = id_funct[4];
        id_dec.rd     = id_funct[4] ? LR_REG : '0;
        id_dec.wb_sel = id_funct[4] ? WB_LINK : WB_ALU;
      end
      default: ;
    endcase
  end

  // Flags are cpsr = {N, Z, C, V}.
  always_comb begin
    cond_pass = 1'b0;
    case (ex_q.cond)
      4'h0: cond_pass = cpsr[2];
      4'h1: cond_pass = ~cpsr[2];
      4'h2: cond_pass = cpsr[1];
      4'h3: cond_pass = ~cpsr[1];
      4'h4: cond_pass = cpsr[3];
      4'h5: cond_pass = ~cpsr[3];
      4'h6: cond_pass = cpsr[0];
      4'h7: cond_pass = ~cpsr[0];
      4'h8: cond_pass = cpsr[1] & ~cpsr[2];
      4'h9: cond_pass = ~cpsr[1] | cpsr[2];
      4'hA: cond_pass = (cpsr[3] == cpsr[0]);
      4'hB: cond_pass = (cpsr[3] != cpsr[0]);
      4'hC: cond_pass = ~cpsr[2] & (cpsr[3] == cpsr[0]);
      4'hD: cond_pass = cpsr[2] | (cpsr[3] != cpsr[0]);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // A load to PC redirecting from MEM also squashes whatever sits in EX.
  assign mem_ld_pc  = mem_q.re && (mem_q.rd == PC_REG);
  assign ex_live    = ex_q.valid && !mem_ld_pc;
  assign ex_cond_ok = ex_live && cond_pass;
  assign redirect   = (ex_cond_ok && (ex_q.branch || ex_q.pc_write)) || mem_ld_pc;
  assign flush_fd   = redirect && (FLUSH_N > 0);

  assign load_use = ex_live && ex_q.re && id_legal &&
                    ((uses_rn && (ex_q.rd == id_rn)) || (uses_rm && (ex_q.rd == id_rm)));
  assign stall_fd = (STALL_EN != 0) && load_use && !redirect;
  assign illegal  = id_valid && (id_opc == OP_UND) && !redirect;
  assign bubble   = !id_legal || stall_fd || redirect;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cpsr  <= '0;
    end else begin
      ex_q  <= bubble ? '0 : id_dec;
      mem_q <= ex_cond_ok ? mem_ctrl_t'{ex_q.re, ex_q.we, ex_q.byte_acc, ex_q.wr_en,
                                        ex_q.rd, ex_q.wb_sel} : '0;
      wb_q  <= wb_ctrl_t'{mem_q.wr_en, mem_q.rd, mem_q.wb_sel};
      if (ex_cond_ok && ex_q.sets) cpsr <= ex_nzcv;
    end
  end

  assign ex_alufun = ex_q.alufun;
  assign ex_imm    = ex_q.imm;
  assign mem_re    = mem_q.re;
  assign mem_we    = mem_q.we;
  assign mem_byte  = mem_q.byte_acc;
  assign wb_we     = wb_q.wr_en;
  assign wb_rd     = wb_q.rd;
  assign wb_sel    = wb_q.wb_sel;

endmodule
